ram_burst_master: RTL and testbench
===================================

Name: ram_burst_master

Overview:
- Initiator-side controller for the team's single-port synchronous RAM. The RAM has one address, a wr strobe, registered dout, 1-cycle read latency and no read while writing.
- Accepts burst commands (start address, length, direction) and converts them into RAM cycles.
- Write bursts: accepts a valid/ready input data stream and writes it to RAM.
- Read bursts: reads RAM and returns data on a valid/ready output stream, with full backpressure and no data loss.
- Sits between a DMA/host agent and one RAM instance.

Parameters:
- data_width, 8, RAM word width.
- addr_width, 4, RAM address width; depth = 2**addr_width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  addr_width  start address.
- cmd_len  in  addr_width  beats minus 1 (1..2**addr_width beats).
- wdata_valid  in  1  write data offered.
- wdata_ready  out  1  write data accepted.
- wdata  in  data_width  write data.
- rdata_valid  out  1  read data offered.
- rdata_ready  in  1  read data accepted.
- rdata  out  data_width  read data.
- rdata_last  out  1  marks final read beat.
- busy  out  1  burst in progress (state != IDLE).
- done  out  1  one-cycle pulse on burst completion.
- ram_wr  out  1  to RAM wr.
- ram_addr  out  addr_width  to RAM addr.
- ram_din  out  data_width  to RAM din.
- ram_dout  in  data_width  from RAM dout.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; address/beat counters = 0; read buffer emptied; in-flight flag = 0.
  - Outputs: done = 0, rdata_valid = 0, rdata_last = 0, rdata = 0, ram_wr = 0, ram_addr = 0, ram_din = 0, busy = 0, cmd_ready = 0 while in reset.
  - Reset mid-burst abandons the burst with no completion pulse; RAM contents already written stay as written.
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: latch addr, len and direction; beat count = 0; go to WRITE or READ next cycle.
- WRITE:
  - wdata_ready = 1.
  - ram_wr = wdata_valid, ram_addr = current address, ram_din = wdata (combinational). Each write lands at the clock edge of its handshake; 1 beat/cycle.
  - Per beat: address increments modulo 2**addr_width (wrap from max to 0); beat count increments.
  - Handshake on beat len: go to IDLE; done = 1 in the following cycle.
  - wdata_valid low: no RAM write, no state change.
- READ:
  - ram_wr = 0 always.
  - Issue condition (all must hold):
    - issued beats <= len;
    - (buffer count + in-flight - pop) < 2, where pop = rdata_valid & rdata_ready.
  - On issue: ram_addr = current address, in-flight flag set for the next cycle, address increments with wrap.
  - In a cycle with in-flight set, ram_dout is pushed into a 2-entry FIFO. The FIFO head drives rdata/rdata_valid; rdata_last = 1 when the head is beat len.
  - Pop of the last beat: go to IDLE; done = 1 in the following cycle.
  - Latency: first rdata_valid in the 3rd cycle after the command-handshake cycle.
  - With rdata_ready held high: 1 beat/cycle sustained.
  - rdata_ready low: at most 2 beats buffered; issue stalls; no beat dropped or duplicated; rdata stable while valid & !ready.
- In IDLE and READ, ram_din holds its last value; in IDLE, ram_addr holds its last value. RAM dout churn while no read is in flight is ignored.
- cmd_ready = 0 while busy; commands are not queued.
- Burst length 2**addr_width covers the whole RAM; addresses wrap back to the start address.

Decomposition:
- Shared package/include ram_master_defs: FSM state encodings (IDLE/WRITE/READ), the read-buffer depth constant (2), and the beat-count width rule (addr_width).
- Sub-module ram_rd_buf: 2-entry data FIFO with {data, last}, push/pop, count output. Simultaneous push and pop allowed at any occupancy, including full.

Test Plan:
- Write burst: addr=14, len=3, wdata 0xA0..0xA3 with valid held high → RAM[14]=A0, [15]=A1, [0]=A2, [1]=A3 (wrap); done pulses 1 cycle after the 4th handshake.
- Read back: read burst addr=14, len=3, rdata_ready=1 → rdata A0, A1, A2, A3 on consecutive cycles starting cycle 3 after the command; rdata_last only on A3.
- Backpressure: read len=7 with rdata_ready toggling 1,0,0,1,... → all 8 words in address order, none lost or duplicated; rdata held constant while stalled; buffer never exceeds 2.
- Gapped writes: write len=2 with wdata_valid 1,0,1,0,1 → exactly 3 RAM writes (ram_wr high 3 cycles); cmd_ready stays 0 until completion.
- Full-depth burst: len=15 write then read from addr=5 → 16 beats, address wraps 15→0, data matches.
- Reset mid-read: rst_n low after 2 beats → rdata_valid, ram_wr and busy drop immediately, no done pulse; after release, a new command is accepted in IDLE.

Source files
------------

// File: rtl/ram_burst_master_pkg.sv
// Shared definitions for the RAM burst master: FSM states, read-buffer sizing
// and the beat-counter width rule.
package ram_burst_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam int unsigned rd_buf_depth = 2;
  localparam int unsigned rd_cnt_w     = 2;

  // Beat counters must span a full-RAM burst of 2**addr_width beats.
  function automatic int unsigned beat_width(input int unsigned addr_width);
    return addr_width;
  endfunction

endpackage

// File: rtl/ram_burst_master_if.sv
// Command, write-data and read-data streams between a host agent and the
// RAM burst master.
interface ram_burst_master_if #(
  parameter int unsigned data_width = 8,
  parameter int unsigned addr_width = 4
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [addr_width-1:0] cmd_addr;
  logic [addr_width-1:0] cmd_len;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [data_width-1:0] wdata;
  logic                  rdata_valid;
  logic                  rdata_ready;
  logic [data_width-1:0] rdata;
  logic                  rdata_last;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready,
    output cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last
  );

endinterface

// File: rtl/ram_burst_master_rd_buf.sv
// Two-entry read-data FIFO carrying {data, last}; push and pop may coincide
// at any occupancy, including full.
module ram_burst_master_rd_buf
  import ram_burst_master_pkg::*;
#(
  parameter int unsigned data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [data_width-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [data_width-1:0] head_data,
  output logic                  head_last,
  output logic                  head_valid,
  output logic [rd_cnt_w-1:0]   count
);

  logic [data_width-1:0] data0_q, data0_d, data1_q, data1_d;
  logic                  last0_q, last0_d, last1_q, last1_d;
  logic [rd_cnt_w-1:0]   count_q, count_d, kept;
  logic                  do_pop;

  assign do_pop = pop && (count_q != '0);
  assign kept   = count_q - rd_cnt_w'(do_pop);

  // Pop shifts slot 1 into the head; push lands in the first free slot after that.
  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    count_d = kept;
    if (do_pop) begin
      data0_d = data1_q;
      last0_d = last1_q;
    end
    if (push && (kept < rd_cnt_w'(rd_buf_depth))) begin
      if (kept == '0) begin
        data0_d = push_data;
        last0_d = push_last;
      end else begin
        data1_d = push_data;
        last1_d = push_last;
      end
      count_d = kept + rd_cnt_w'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data0_q <= '0;
      data1_q <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      count_q <= '0;
    end else begin
      data0_q <= data0_d;
      data1_q <= data1_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
      count_q <= count_d;
    end
  end

  assign head_valid = (count_q != '0);
  assign head_data  = data0_q;
  assign head_last  = last0_q & head_valid;
  assign count      = count_q;

endmodule

// File: rtl/ram_burst_master.sv
// Burst controller for a single-port synchronous RAM: turns {addr, len, dir}
// commands into RAM cycles with valid/ready write and read data streams.
module ram_burst_master
  import ram_burst_master_pkg::*;
#(
  parameter int unsigned data_width = 8,
  parameter int unsigned addr_width = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_burst_master_if.slave     bus,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_wr,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_dout
);

  localparam int unsigned beat_w = beat_width(addr_width);
  localparam int unsigned cnt_w  = beat_w + 1;

  state_t                state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d, addr_hold_q;
  logic [beat_w-1:0]     len_q, len_d, beat_q, beat_d;
  logic [cnt_w-1:0]      issued_q, issued_d;
  logic                  inflight_q, inflight_d, inflight_last_q, inflight_last_d;
  logic [data_width-1:0] din_hold_q;
  logic                  cmd_ready_q, done_q, done_d;

  logic [data_width-1:0] buf_data;
  logic                  buf_last, buf_valid, pop, issue, wr_hs;
  logic [rd_cnt_w-1:0]   buf_count;
  logic [2:0]            occ;

  assign wr_hs = (state_q == WRITE) && bus.wdata_valid;
  assign pop   = buf_valid && bus.rdata_ready;
  // Occupancy the buffer will hold once the in-flight word lands and any pop retires.
  assign occ   = 3'(buf_count) + 3'(inflight_q) - 3'(pop);
  assign issue = (state_q == READ) && (issued_q <= cnt_w'(len_q)) && (occ < 3'd2);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    len_d           = len_q;
    beat_d          = beat_q;
    issued_d        = issued_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    done_d          = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          addr_d   = bus.cmd_addr;
          len_d    = bus.cmd_len;
          beat_d   = '0;
          issued_d = '0;
          state_d  = bus.cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wr_hs) begin
          addr_d = addr_q + addr_width'(1);
          beat_d = beat_q + beat_w'(1);
          if (beat_q == len_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          inflight_d      = 1'b1;
          inflight_last_d = (issued_q == cnt_w'(len_q));
          addr_d          = addr_q + addr_width'(1);
          issued_d        = issued_q + cnt_w'(1);
        end
        if (pop && buf_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      beat_q          <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      addr_hold_q     <= '0;
      din_hold_q      <= '0;
      cmd_ready_q     <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      beat_q          <= beat_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      addr_hold_q     <= ram_addr;
      din_hold_q      <= ram_din;
      cmd_ready_q     <= (state_d == IDLE);
      done_q          <= done_d;
    end
  end

  ram_burst_master_rd_buf #(
    .data_width (data_width)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight_q),
    .push_data  (ram_dout),
    .push_last  (inflight_last_q),
    .pop        (pop),
    .head_data  (buf_data),
    .head_last  (buf_last),
    .head_valid (buf_valid),
    .count      (buf_count)
  );

  // RAM address/data hold their last driven value outside an active cycle.
  assign ram_wr   = wr_hs;
  assign ram_addr = ((state_q == WRITE) || issue) ? addr_q : addr_hold_q;
  assign ram_din  = (state_q == WRITE) ? bus.wdata : din_hold_q;

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.wdata_ready = (state_q == WRITE);
  assign bus.rdata_valid = buf_valid;
  assign bus.rdata       = buf_data;
  assign bus.rdata_last  = buf_last;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;

endmodule

// File: tb/tb_ram_burst_master.sv
// Randomized bench for ram_burst_master with a behavioural RAM and a
// word-array reference of what each burst should write or return.
module tb_ram_burst_master;

  localparam int unsigned dw    = 8;
  localparam int unsigned aw    = 4;
  localparam int unsigned depth = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          busy, done, ram_wr;
  logic [aw-1:0] ram_addr;
  logic [dw-1:0] ram_din, ram_dout;

  logic [dw-1:0] ram_mem [depth];
  logic [dw-1:0] exp_mem [depth];

  int tests = 0;
  int fails = 0;

  ram_burst_master_if #(.data_width(dw), .addr_width(aw)) bus ();

  ram_burst_master #(.data_width(dw), .addr_width(aw)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .ram_wr   (ram_wr),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM: write or registered read, never both.
  always @(posedge clk) begin
    if (ram_wr) ram_mem[ram_addr] <= ram_din;
    else        ram_dout <= ram_mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue_cmd(input logic wr, input logic [aw-1:0] a, input logic [aw-1:0] l);
    int t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (bus.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL cmd_accept: cmd_ready=%b, required 1", bus.cmd_ready);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_write(input logic [aw-1:0] a, input logic [aw-1:0] l, input int base, input int mode);
    int sent = 0, cyc = 0, wr_cnt = 0, bad = 0;
    logic v;
    logic [dw-1:0] d;
    logic [aw-1:0] ea;
    issue_cmd(1'b1, a, l);
    while (sent <= int'(l) && cyc < 200) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      d = (base >= 0) ? dw'(base + sent) : dw'($urandom);
      bus.wdata_valid = v;
      bus.wdata       = d;
      @(negedge clk);
      ea = aw'(int'(a) + sent);
      tests++;
      if (bus.cmd_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || bus.wdata_ready !== 1'b1) begin
        fails++;
        $display("FAIL wr_status: cmd_ready=%b busy=%b done=%b wdata_ready=%b, required 0 1 0 1",
                 bus.cmd_ready, busy, done, bus.wdata_ready);
      end
      tests++;
      if (ram_wr !== v) begin
        fails++;
        $display("FAIL wr_strobe: ram_wr=%b, required %b", ram_wr, v);
      end
      if (ram_wr === 1'b1) wr_cnt++;
      if (v) begin
        tests++;
        if (ram_addr !== ea || ram_din !== d) begin
          fails++;
          $display("FAIL wr_beat: addr=%h din=%h, required addr=%h din=%h", ram_addr, ram_din, ea, d);
        end
        exp_mem[ea] = d;
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.wdata_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.wdata_ready !== 1'b0) begin
      fails++;
      $display("FAIL wr_done: done=%b busy=%b wdata_ready=%b, required 1 0 0", done, busy, bus.wdata_ready);
    end
    tests++;
    if (wr_cnt != int'(l) + 1) begin
      fails++;
      $display("FAIL wr_count: %0d RAM writes, required %0d", wr_cnt, int'(l) + 1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL wr_done_pulse: done=%b one cycle later, required 0", done);
    end
    for (int i = 0; i < int'(depth); i++) if (ram_mem[i] !== exp_mem[i]) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL wr_contents: %0d RAM words differ, required 0", bad);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_read(input logic [aw-1:0] a, input logic [aw-1:0] l, input int mode);
    int got = 0, cyc = 1, first = -1, lastc = -1;
    logic r, pv = 1'b0, pr = 1'b0;
    logic [dw-1:0] pd = '0;
    logic [aw-1:0] ea;
    issue_cmd(1'b0, a, l);
    while (got <= int'(l) && cyc < 300) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (((cyc - 1) % 3) == 0) : 1'($urandom_range(0, 1));
      bus.rdata_ready = r;
      @(negedge clk);
      tests++;
      if (busy !== 1'b1 || done !== 1'b0 || bus.cmd_ready !== 1'b0 || ram_wr !== 1'b0) begin
        fails++;
        $display("FAIL rd_status: busy=%b done=%b cmd_ready=%b ram_wr=%b, required 1 0 0 0",
                 busy, done, bus.cmd_ready, ram_wr);
      end
      tests++;
      if (dut.u_buf.count_q > 2'd2) begin
        fails++;
        $display("FAIL rd_occupancy: %0d buffered, required at most 2", dut.u_buf.count_q);
      end
      if (pv && !pr) begin
        tests++;
        if (bus.rdata_valid !== 1'b1 || bus.rdata !== pd) begin
          fails++;
          $display("FAIL rd_stable: valid=%b rdata=%h, required 1 %h", bus.rdata_valid, bus.rdata, pd);
        end
      end
      if (bus.rdata_valid === 1'b1 && first < 0) first = cyc;
      if (bus.rdata_valid === 1'b1 && r) begin
        ea = aw'(int'(a) + got);
        tests++;
        if (bus.rdata !== exp_mem[ea] || bus.rdata_last !== (got == int'(l))) begin
          fails++;
          $display("FAIL rd_beat %0d: rdata=%h last=%b, required %h %b",
                   got, bus.rdata, bus.rdata_last, exp_mem[ea], (got == int'(l)));
        end
        got++;
        lastc = cyc;
      end
      pv = bus.rdata_valid;
      pr = r;
      pd = bus.rdata;
      @(posedge clk); #1;
      cyc++;
    end
    bus.rdata_ready = 1'b0;
    tests++;
    if (got != int'(l) + 1) begin
      fails++;
      $display("FAIL rd_count: %0d beats, required %0d", got, int'(l) + 1);
    end
    if (mode == 0) begin
      tests++;
      if (first != 3 || lastc != 3 + int'(l)) begin
        fails++;
        $display("FAIL rd_latency: first=%0d last=%0d, required 3 %0d", first, lastc, 3 + int'(l));
      end
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.rdata_valid !== 1'b0) begin
      fails++;
      $display("FAIL rd_done: done=%b busy=%b rdata_valid=%b, required 1 0 0", done, busy, bus.rdata_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL rd_done_pulse: done=%b one cycle later, required 0", done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (bus.cmd_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ram_wr !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: cmd_ready=%b busy=%b done=%b ram_wr=%b, required 0 0 0 0",
               bus.cmd_ready, busy, done, ram_wr);
    end
    tests++;
    if (bus.rdata_valid !== 1'b0 || bus.rdata_last !== 1'b0 || bus.rdata !== '0 ||
        ram_addr !== '0 || ram_din !== '0) begin
      fails++;
      $display("FAIL reset_data: rvalid=%b rlast=%b rdata=%h addr=%h din=%h, required all 0",
               bus.rdata_valid, bus.rdata_last, bus.rdata, ram_addr, ram_din);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: cmd_ready=%b busy=%b, required 1 0", bus.cmd_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_read();
    int got = 0, cyc = 0;
    issue_cmd(1'b0, 4'd3, 4'd7);
    bus.rdata_ready = 1'b1;
    while (got < 2 && cyc < 20) begin
      @(negedge clk);
      if (bus.rdata_valid === 1'b1) got++;
      @(posedge clk); #1;
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.rdata_valid !== 1'b0 || ram_wr !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        bus.cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: rvalid=%b ram_wr=%b busy=%b done=%b cmd_ready=%b, required all 0",
               bus.rdata_valid, ram_wr, busy, done, bus.cmd_ready);
    end
    bus.rdata_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || bus.rdata_valid !== 1'b0) begin
        fails++;
        $display("FAIL mid_reset_nodone: done=%b rvalid=%b, required 0 0", done, bus.rdata_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < int'(depth); i++) begin
      ram_mem[i] = '0;
      exp_mem[i] = '0;
    end
    ram_dout        = '0;
    rst_n           = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_len     = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    bus.rdata_ready = 1'b0;

    test_reset();
    run_write(4'd14, 4'd3, 'hA0, 0);
    run_read(4'd14, 4'd3, 0);
    run_write(4'd2, 4'd7, -1, 2);
    run_read(4'd2, 4'd7, 1);
    run_write(4'd9, 4'd2, -1, 1);
    run_read(4'd9, 4'd2, 0);
    run_write(4'd5, 4'd15, -1, 0);
    run_read(4'd5, 4'd15, 0);
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1)
        run_write(aw'($urandom), aw'($urandom), -1, int'($urandom_range(0, 2)));
      else
        run_read(aw'($urandom), aw'($urandom), int'($urandom_range(0, 2)));
    end
    test_reset_mid_read();
    run_write(4'd0, 4'd1, -1, 0);
    run_read(4'd0, 4'd15, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
